// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool with ReLU floor, fed one conv pixel per handshake in raster order.
// A line buffer of horizontal pair maxima from even rows is combined with the odd row to form each window.
module maxpool2x2_stream #(
   parameter int MAX_N  = 62,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 6
) (
   input  logic                     clk,
   input  logic                     reset_b,
   input  logic                     start,
   input  logic [CNT_W:0]           cfg_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     busy,
   output logic                     done,
   output logic [1:0]               dbg_state
);

   localparam int LB_N = MAX_N / 2;
   localparam int K_W  = CNT_W - 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                   state;
   logic [CNT_W:0]           n_reg;
   logic [CNT_W-1:0]         row;
   logic [CNT_W-1:0]         col;
   logic signed [DATA_W-1:0] pair_q;
   logic signed [DATA_W-1:0] line_buf [LB_N];
   logic signed [DATA_W-1:0] lb_rd;
   logic signed [DATA_W-1:0] win_max;
   logic [K_W-1:0]           k;
   logic [CNT_W:0]           two_p;
   logic [CNT_W:0]           n_m1;
   logic                     acc;
   logic                     in_win;
   logic                     col_last;
   logic                     row_last;
   logic                     win_end;

   function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // Handshake: a pixel moves when in_valid && in_ready; a result moves when out_valid && out_ready.
   // Input is blocked while a result is held and not being taken, so the single output register never overflows.
   assign in_ready  = (state == S_RUN) && !(out_valid && !out_ready);
   assign acc       = in_valid && in_ready;
   assign dbg_state = state;

   assign two_p    = {n_reg[CNT_W:1], 1'b0};
   assign n_m1     = n_reg - 1'b1;
   assign col_last = ({1'b0, col} == n_m1);
   assign row_last = ({1'b0, row} == n_m1);
   // Odd trailing row/column of an odd-sized map lies outside every window.
   assign in_win   = ({1'b0, col} < two_p) && ({1'b0, row} < two_p);
   assign win_end  = acc && in_win && row[0] && col[0];
   assign k        = col[CNT_W-1:1];
   assign lb_rd    = line_buf[k];
   assign win_max  = smax(smax(lb_rd, pair_q), smax(in_data, {DATA_W{1'b0}}));

   always_ff @(posedge clk) begin
      if (acc && in_win) begin
         if (!col[0]) begin
            pair_q <= in_data;
         end else if (!row[0]) begin
            line_buf[k] <= smax(pair_q, in_data);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset_b) begin
         state     <= S_IDLE;
         n_reg     <= '0;
         row       <= '0;
         col       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         // A new result takes priority over retiring the old one in the same cycle.
         if (win_end) begin
            out_valid <= 1'b1;
            out_data  <= win_max;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               if (start) begin
                  n_reg <= cfg_n;
                  row   <= '0;
                  col   <= '0;
                  busy  <= 1'b1;
                  state <= (cfg_n >= (CNT_W+1)'(2)) ? S_RUN : S_DONE;
               end
            end
            S_RUN: begin
               if (acc) begin
                  if (col_last) begin
                     col <= '0;
                     row <= row + 1'b1;
                     if (row_last) state <= S_DRAIN;
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (!out_valid || out_ready) state <= S_DONE;
            end
            S_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream: ramp maps, odd size, negative window, degenerate sizes,
// output stall, mid-frame reset and a randomized 62x62 frame against a window-max model.
module tb_maxpool2x2_stream;

   localparam int MAX_N  = 62;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 6;

   logic                     clk = 1'b0;
   logic                     reset_b = 1'b1;
   logic                     start = 1'b0;
   logic [CNT_W:0]           cfg_n = '0;
   logic                     in_valid = 1'b0;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_data = '0;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] out_data;
   logic                     busy;
   logic                     done;
   logic [1:0]               dbg_state;

   logic ready_man  = 1'b1;
   logic ready_rand = 1'b0;
   logic rnd_ready  = 1'b1;
   assign out_ready = ready_rand ? rnd_ready : ready_man;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int acc_cnt = 0;
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] got_q[$];
   logic [DATA_W-1:0] pix_q[$];
   logic signed [DATA_W-1:0] img [MAX_N][MAX_N];

   always #5 clk = ~clk;

   maxpool2x2_stream #(.MAX_N(MAX_N), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset_b(reset_b), .start(start), .cfg_n(cfg_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .done(done), .dbg_state(dbg_state)
   );

   always @(negedge clk) begin
      if (!reset_b) begin
         if (out_valid && out_ready) got_q.push_back(out_data);
         if (in_valid && in_ready) acc_cnt++;
         if (done) done_cnt++;
      end
   end

   always begin
      @(posedge clk);
      #1;
      rnd_ready = ($urandom_range(0, 1) == 1);
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_sb();
      exp_q.delete();
      got_q.delete();
      pix_q.delete();
      done_cnt = 0;
      acc_cnt = 0;
   endtask

   task automatic start_frame(input int n);
      cfg_n = (CNT_W+1)'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
      cfg_n = 7'd3;
   endtask

   task automatic load_ramp(input int count);
      for (int i = 0; i < count; i++) pix_q.push_back(DATA_W'(i));
   endtask

   task automatic feed(input bit gaps);
      int guard = 0;
      while (pix_q.size() > 0 && guard < 30000) begin
         in_data  = pix_q[0];
         in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(negedge clk);
         if (in_valid && in_ready) void'(pix_q.pop_front());
         tick();
         guard++;
      end
      in_valid = 1'b0;
      check("feed_all_accepted", pix_q.size(), 0);
   endtask

   task automatic wait_idle(input string tag);
      int guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (busy && guard < 2000);
      check({tag, "_idle_in_time"}, busy, 0);
      check({tag, "_done_with_busy_fall"}, done, 1);
      tick();
      tick();
      check({tag, "_done_once"}, done_cnt, 1);
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_out_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check({tag, "_out_value"}, got_q[i], exp_q[i]);
   endtask

   task automatic reset_dut();
      reset_b = 1'b1;
      tick();
      tick();
      reset_b = 1'b0;
   endtask

   initial begin
      reset_dut();
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_state", dbg_state, 0);

      // N=4 ramp, free flowing
      clear_sb();
      load_ramp(16);
      exp_q = '{8'd5, 8'd7, 8'd13, 8'd15};
      start_frame(4);
      check("n4_busy_after_start", busy, 1);
      feed(1'b0);
      wait_idle("n4");
      check_outputs("n4");

      // N=4 ramp with a 5-cycle downstream stall on the first result
      clear_sb();
      load_ramp(16);
      exp_q = '{8'd5, 8'd7, 8'd13, 8'd15};
      ready_man = 1'b0;
      start_frame(4);
      fork
         feed(1'b0);
         begin
            int guard = 0;
            do begin
               @(negedge clk);
               guard++;
            end while (!out_valid && guard < 200);
            for (int i = 0; i < 5; i++) begin
               if (i > 0) @(negedge clk);
               check("stall_out_valid", out_valid, 1);
               check("stall_out_data", out_data, 5);
               check("stall_in_ready", in_ready, 0);
               tick();
            end
            ready_man = 1'b1;
         end
      join
      wait_idle("stall");
      check_outputs("stall");

      // N=5 ramp: trailing column and row dropped
      clear_sb();
      load_ramp(25);
      exp_q = '{8'd6, 8'd8, 8'd16, 8'd18};
      start_frame(5);
      feed(1'b0);
      wait_idle("n5");
      check("n5_inputs_accepted", acc_cnt, 25);
      check_outputs("n5");

      // N=2 all-negative window floors to zero
      clear_sb();
      pix_q = '{8'hFD, 8'hF9, 8'hFF, 8'h80};
      exp_q = '{8'd0};
      start_frame(2);
      feed(1'b0);
      wait_idle("n2");
      check_outputs("n2");

      // N=1: no outputs, done two cycles after start
      clear_sb();
      start_frame(1);
      check("n1_in_ready", in_ready, 0);
      check("n1_done_early", done, 0);
      tick();
      check("n1_done", done, 1);
      check("n1_busy_low", busy, 0);
      tick();
      check("n1_done_pulse", done, 0);
      check("n1_no_outputs", got_q.size(), 0);

      // N=62 random data, random in_valid and out_ready, checked against a window-max model
      clear_sb();
      for (int r = 0; r < MAX_N; r++)
         for (int c = 0; c < MAX_N; c++) begin
            img[r][c] = DATA_W'($urandom_range(0, 255));
            pix_q.push_back(img[r][c]);
         end
      for (int pr = 0; pr < MAX_N / 2; pr++)
         for (int pc = 0; pc < MAX_N / 2; pc++) begin
            logic signed [DATA_W-1:0] m;
            m = '0;
            for (int dr = 0; dr < 2; dr++)
               for (int dc = 0; dc < 2; dc++)
                  if (img[2*pr+dr][2*pc+dc] > m) m = img[2*pr+dr][2*pc+dc];
            exp_q.push_back(m);
         end
      ready_rand = 1'b1;
      start_frame(62);
      feed(1'b1);
      wait_idle("n62");
      ready_rand = 1'b0;
      check_outputs("n62");

      // Mid-frame reset after 9 pixels, then a clean frame
      clear_sb();
      load_ramp(9);
      start_frame(4);
      feed(1'b0);
      reset_b = 1'b1;
      tick();
      check("midrst_in_ready", in_ready, 0);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_data", out_data, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_state", dbg_state, 0);
      reset_b = 1'b0;
      tick();
      clear_sb();
      load_ramp(16);
      exp_q = '{8'd5, 8'd7, 8'd13, 8'd15};
      start_frame(4);
      feed(1'b0);
      wait_idle("after_rst");
      check_outputs("after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/maxpool2x2_stream.md
Name: maxpool2x2_stream

Overview:
- Streaming 2x2/stride-2 max-pool stage directly downstream of the 3x3 convolution + ReLU stage. Upstream feeds it the conv output map.
- Accepts the NxN conv output map one signed 8-bit pixel per handshake, in raster order (row 0 col 0 first).
- Emits floor(N/2) x floor(N/2) pooled pixels in raster order to the fully-connected stage.
- Holds one line buffer of pair maxima, so the full map is never stored.

Parameters:
- MAX_N, 62, largest supported conv output width/height
- DATA_W, 8, pixel width (signed two's complement)
- CNT_W, 6, width of row/col counters; must satisfy 2^CNT_W >= MAX_N

Ports:
- clk  input  1  clock, all logic on rising edge
- reset_b  input  1  synchronous reset, active-high (1 = reset)
- start  input  1  1-cycle pulse; begins a frame; ignored unless in IDLE
- cfg_n  input  CNT_W+1  conv map width/height N, sampled on accepted start
- in_valid  input  1  upstream pixel valid
- in_ready  output  1  stage accepts pixel this cycle
- in_data  input  DATA_W  conv pixel, signed
- out_valid  output  1  pooled pixel valid
- out_ready  input  1  downstream accepts pooled pixel
- out_data  output  DATA_W  pooled pixel, signed
- busy  output  1  high in any state but IDLE
- done  output  1  1-cycle pulse at frame end

Behaviour:
- Reset (reset_b=1 at clk edge), reset values:
  - state=IDLE; in_ready=0, out_valid=0, out_data=0, busy=0, done=0.
  - Row/col counters cleared; line buffer contents don't-care.
  - Reset wins over every other input in the same cycle. Mid-frame reset abandons the frame and drops any held output.
- States:
  - IDLE: start=1 latches N=cfg_n, clears counters. Next state RUN if N>=2, else DONE.
  - RUN: consumes exactly N*N input pixels, then goes to DRAIN.
  - DRAIN: waits for out_valid=0 (or out_valid&&out_ready this cycle), then goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Input acceptance:
  - in_ready = (state==RUN) && !(out_valid && !out_ready).
  - A pixel is consumed when in_valid && in_ready.
  - col increments per pixel and wraps at N-1 to 0 with row+1.
- Pooling, with P=floor(N/2), r=row, c=col, pair index k=c>>1:
  - Pixels with c>=2P or r>=2P (odd-N trailing column/row) are consumed and discarded.
  - Even r, even c: hold pixel in pair register.
  - Even r, odd c: line_buf[k] = max(pair register, pixel).
  - Odd r, even c: hold pixel in pair register.
  - Odd r, odd c: result = max(0, line_buf[k], pair register, pixel), loaded into out_data with out_valid=1 on the next edge. Latency is 1 cycle from acceptance of the 4th window pixel.
- Arithmetic:
  - All compares are signed DATA_W.
  - Results are floored at 0; an all-negative window yields 0.
  - No widening and no saturation needed, since the result is within the input range.
- Output handshake:
  - out_data is stable while out_valid && !out_ready.
  - out_valid clears on out_valid && out_ready unless a new result loads in the same cycle; load wins.
  - Back-to-back results are possible only with at least 1 intervening pixel, so one output register suffices.
- Other rules:
  - start while busy is ignored; cfg_n changes mid-frame are ignored.
  - Pooled output count per frame is exactly P*P. N=2 gives 1 output; N=0 or 1 gives 0 outputs and done 2 cycles after start.

Test Plan:
- N=4, inputs 0..15 raster, in_valid always 1, out_ready always 1 -> outputs 5,7,13,15 in order; done pulses once; busy falls with done.
- N=4, same data, out_ready held 0 for 5 cycles after first out_valid -> out_data holds 5, in_ready=0 during stall, no loss or duplication; final sequence unchanged.
- N=5, inputs 0..24 -> outputs 6,8,16,18; all 25 inputs accepted; trailing column/row dropped.
- N=2, inputs -3,-7,-1,-128 -> single output 0; N=1 -> no outputs, done 2 cycles after start.
- N=62, random signed data with random in_valid/out_ready -> 961 outputs match reference model max(0, window max).
- N=4, assert reset_b=1 after 9 inputs -> next cycle all outputs at reset values; new start with N=4 ramp yields 5,7,13,15.
